uart_cmd_fifo_rx: RTL

Parametrised successor to the command UART receiver that feeds `dig_core` from the BLE112 module. It receives asynchronous serial frames on `RX` and queues decoded command bytes in a small FIFO, so that back-to-back commands are not lost while the core is busy. It reports framing and overrun errors. With `FIFO_DEPTH=1` it presents the same `rdy`/`clr_rdy`/`cmd` handshake as the existing single-register receiver.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/cmd_fifo.sv | 79 +++++++
 rtl/uart_cmd_fifo_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the command UART receiver and its FIFO.
package uart_pkg;

  localparam int DEFAULT_BAUD_DIV   = 2604;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_COUNT_W = count_width(DEFAULT_FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command FIFO with occupancy count; pop_dat shows the head entry combinationally.
// Push lands on the next edge; a push into a full FIFO is only accepted alongside a pop.
module cmd_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  FIFO_DEPTH = 4,
  localparam int CNT_W      = count_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_fifo_rx.sv
// Command UART receiver feeding a small FIFO; byte appears one cycle after the stop sample.
// No backpressure on the line: a full FIFO drops the byte and flags overrun. UART_PARITY_EN adds even parity.
module uart_cmd_fifo_rx
  import uart_pkg::*;
#(
  parameter int  BAUD_DIV    = DEFAULT_BAUD_DIV,
  parameter int  DATA_W      = 8,
  parameter int  FIFO_DEPTH  = 4,
  parameter int  SYNC_STAGES = 2,
  localparam int CNT_W       = count_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic [DATA_W-1:0] cmd,
  output logic              rdy,
  input  logic              clr_rdy,
  output logic [CNT_W-1:0]  count,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_err
`ifdef UART_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int BCNT_W = $clog2(BAUD_DIV + 1);
  localparam int IDX_W  = 4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic                   rx_s, rx_fall, expire;
  rx_state_e              state_q, state_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   push, set_overrun, set_frame_err;
  logic                   fifo_full, fifo_empty;
`ifdef UART_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
  logic                   set_parity_err;
`endif

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], RX};
  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign rx_prev_d = rx_s;
  assign rx_fall   = rx_prev_q & ~rx_s;
  // Counter reaching 1 marks the sample cycle, so a load of N samples N cycles later.
  assign expire    = (bcnt_q == BCNT_W'(1));

  always_comb begin
    state_d       = state_q;
    bcnt_d        = (state_q == ST_IDLE) ? bcnt_q : bcnt_q - 1'b1;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    push          = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d      = par_bad_q;
    set_parity_err = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d = ST_START;
          bcnt_d  = BCNT_W'(BAUD_DIV / 2);
        end
      end
      ST_START: begin
        if (expire) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bcnt_d    = BCNT_W'(BAUD_DIV);
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          shreg_d   = {rx_s, shreg_q[DATA_W-1:1]};
          bcnt_d    = BCNT_W'(BAUD_DIV);
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (expire) begin
          par_bad_d = rx_s ^ (^shreg_q);
          bcnt_d    = BCNT_W'(BAUD_DIV);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (expire) begin
          state_d = ST_IDLE;
          if (!rx_s) begin
            set_frame_err = 1'b1;
`ifdef UART_PARITY_EN
          end else if (par_bad_q) begin
            set_parity_err = 1'b1;
`endif
          end else begin
            push        = 1'b1;
            // A pop in the same cycle frees the slot, so only a pop-less full FIFO overruns.
            set_overrun = fifo_full & ~clr_rdy;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign overrun_d   = set_overrun | (overrun_q & ~clr_err);
  assign frame_err_d = set_frame_err | (frame_err_q & ~clr_err);
`ifdef UART_PARITY_EN
  assign parity_err_d = set_parity_err | (parity_err_q & ~clr_err);
  assign parity_err   = parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bcnt_q      <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  cmd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (shreg_q),
    .pop      (clr_rdy),
    .pop_dat  (cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign rdy       = ~fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
